target_ramp: RTL and testbench

TARGET_RAMP -- requirements
Module: target_ramp

---
 rtl/target_ramp.sv | 165 ++++++++++++++++
 tb/tb_target_ramp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/target_ramp.sv
// target_ramp -- converts a requested code into a target word and moves the
// registered target toward it, either in one jump or in slew-limited steps.
//
// goal = BASE + value * STEP, computed one bit wider than the target so a
// sum that does not fit saturates to all-ones and raises the sticky ovf flag.
//
// Build option:
//   TARGET_RAMP_SLEW_EN  defined   -> slew-limited ramp paced by tick
//                        undefined -> RAMP always jumps to goal on its first
//                                     edge; tick and slew are ignored
//
// Ports:
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high
//   value   in   [VAL_W]   requested code, captured on load
//   load    in   1-cycle strobe; restarts from the current target in any state
//   tick    in   ramp update strobe
//   slew    in   [SLEW_W]  maximum target change per tick, 0 = jump
//   target  out  [TGT_W]   registered target word
//   busy    out  high while a code is being converted or ramped
//   done    out  1-cycle pulse when target reaches goal
//   ovf     out  sticky: the last goal saturated; cleared by reset or load
module target_ramp #(
  parameter int               VAL_W  = 6,
  parameter int               TGT_W  = 32,
  parameter logic [TGT_W-1:0] BASE   = 429482970,
  parameter logic [TGT_W-1:0] STEP   = 430,
  parameter int               SLEW_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  input  logic              tick,
  input  logic [SLEW_W-1:0] slew,
  output logic [TGT_W-1:0]  target,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RAMP = 2'd2
  } state_t;

  localparam int SW = TGT_W + 1;

  state_t             state_reg, state_next;
  logic [TGT_W-1:0]   target_reg, target_next;
  logic [TGT_W-1:0]   goal_reg, goal_next;
  logic [VAL_W-1:0]   value_reg, value_next;
  logic               ovf_reg, ovf_next;
  logic               done_reg, done_next;

  // Goal arithmetic carries one extra bit; a set MSB means the sum overflowed.
  logic [SW-1:0]      sum_w;
  logic [TGT_W-1:0]   goal_calc;

  assign sum_w     = {1'b0, BASE} + ({{(SW-VAL_W){1'b0}}, value_reg} * {1'b0, STEP});
  assign goal_calc = sum_w[TGT_W] ? {TGT_W{1'b1}} : sum_w[TGT_W-1:0];

`ifdef TARGET_RAMP_SLEW_EN
  localparam int CW = (TGT_W > SLEW_W) ? TGT_W : SLEW_W;

  logic               at_goal;
  logic               going_up;
  logic [TGT_W-1:0]   dist;
  logic [CW-1:0]      dist_ext;
  logic [CW-1:0]      slew_ext;
  logic [CW-1:0]      step_ext;
  logic [TGT_W-1:0]   step_amt;
  logic [TGT_W-1:0]   stepped;

  // Distance is always taken as larger-minus-smaller, and the step is
  // clamped to that distance, so the target lands exactly on goal and never
  // wraps or overshoots.
  assign at_goal  = (target_reg == goal_reg);
  assign going_up = (goal_reg > target_reg);
  assign dist     = going_up ? (goal_reg - target_reg) : (target_reg - goal_reg);
  assign dist_ext = CW'(dist);
  assign slew_ext = CW'(slew);
  assign step_ext = (slew_ext < dist_ext) ? slew_ext : dist_ext;
  assign step_amt = step_ext[TGT_W-1:0];
  assign stepped  = going_up ? (target_reg + step_amt) : (target_reg - step_amt);
`else
  // Without the ramp option these inputs have no effect.
  logic unused_ramp_inputs;
  assign unused_ramp_inputs = ^{tick, slew};
`endif

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    goal_next   = goal_reg;
    value_next  = value_reg;
    ovf_next    = ovf_reg;
    done_next   = 1'b0;

    if (load) begin
      // Load wins over tick; target is left where it is so a new ramp
      // (including a reversal) continues from the present value.
      value_next = value;
      ovf_next   = 1'b0;
      state_next = CALC;
    end else begin
      case (state_reg)
        CALC: begin
          goal_next  = goal_calc;
          if (sum_w[TGT_W]) begin
            ovf_next = 1'b1;
          end
          state_next = RAMP;
        end
        RAMP: begin
`ifdef TARGET_RAMP_SLEW_EN
          if ((slew == '0) || at_goal) begin
            target_next = goal_reg;
            state_next  = IDLE;
            done_next   = 1'b1;
          end else if (tick) begin
            target_next = stepped;
            if (stepped == goal_reg) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
`else
          target_next = goal_reg;
          state_next  = IDLE;
          done_next   = 1'b1;
`endif
        end
        default: begin
          // IDLE holds the target and ignores tick.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      target_reg <= BASE;
      goal_reg   <= BASE;
      value_reg  <= '0;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      goal_reg   <= goal_next;
      value_reg  <= value_next;
      ovf_reg    <= ovf_next;
      done_reg   <= done_next;
    end
  end

  assign target = target_reg;
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_target_ramp.sv
// Bench for target_ramp: two instances (default BASE and a BASE near the top
// of the range) share one stimulus stream; a behavioural model is checked
// against both every cycle, plus literal expectations for the directed cases.
module tb_target_ramp;

`ifdef TARGET_RAMP_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam longint MAXV   = 64'hFFFF_FFFF;
  localparam longint BASE_A = 64'd429482970;
  localparam longint BASE_B = 64'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        tick;
  logic [5:0]  value;
  logic [15:0] slew;
  logic [31:0] target_a, target_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  target_ramp dut_a (
    .clk(clk), .reset(reset), .value(value), .load(load), .tick(tick),
    .slew(slew), .target(target_a), .busy(busy_a), .done(done_a), .ovf(ovf_a)
  );

  target_ramp #(.BASE(32'hFFFF_FF00)) dut_b (
    .clk(clk), .reset(reset), .value(value), .load(load), .tick(tick),
    .slew(slew), .target(target_b), .busy(busy_b), .done(done_b), .ovf(ovf_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: phase 0 = idle, 1 = computing goal, 2 = ramping.
  longint m_target[2], m_goal[2], m_code[2];
  int     m_phase[2];
  bit     m_done[2], m_ovf[2];
  bit     m_valid = 1'b0;

  function automatic longint base_of(input int i);
    return (i == 0) ? BASE_A : BASE_B;
  endfunction

  task automatic model_edge(input int i);
    longint sum, d, s;
    if (reset) begin
      m_target[i] = base_of(i);
      m_goal[i]   = base_of(i);
      m_phase[i]  = 0;
      m_done[i]   = 1'b0;
      m_ovf[i]    = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      if (load) begin
        m_code[i]  = longint'(value);
        m_phase[i] = 1;
        m_ovf[i]   = 1'b0;
      end else if (m_phase[i] == 1) begin
        sum = base_of(i) + m_code[i] * 430;
        if (sum > MAXV) begin
          m_goal[i] = MAXV;
          m_ovf[i]  = 1'b1;
        end else begin
          m_goal[i] = sum;
        end
        m_phase[i] = 2;
      end else if (m_phase[i] == 2) begin
        if (!SLEW_EN || slew == 0 || m_target[i] == m_goal[i]) begin
          m_target[i] = m_goal[i];
          m_phase[i]  = 0;
          m_done[i]   = 1'b1;
        end else if (tick) begin
          d = m_goal[i] - m_target[i];
          s = (d < 0) ? -d : d;
          if (longint'(slew) < s) s = longint'(slew);
          m_target[i] = (d < 0) ? m_target[i] - s : m_target[i] + s;
          if (m_target[i] == m_goal[i]) begin
            m_phase[i] = 0;
            m_done[i]  = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_edge(i);
    if (reset) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      chk("a.target", target_a, m_target[0]);
      chk("a.busy",   busy_a,   longint'(m_phase[0] != 0));
      chk("a.done",   done_a,   m_done[0]);
      chk("a.ovf",    ovf_a,    m_ovf[0]);
      chk("b.target", target_b, m_target[1]);
      chk("b.busy",   busy_b,   longint'(m_phase[1] != 0));
      chk("b.done",   done_b,   m_done[1]);
      chk("b.ovf",    ovf_b,    m_ovf[1]);
    end
  end

  // One clock: inputs applied now, sampled at the next rising edge, task
  // returns at the following falling edge.
  task automatic drive(input bit ld, input int v, input bit tk);
    load  = ld;
    value = v[5:0];
    tick  = tk;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    reset = 1'b0;
  endtask

  int n;
  int dones;
  bit seen;

  initial begin
    reset = 1'b1; load = 1'b0; tick = 1'b0; value = '0; slew = '0;

    // Reset state
    do_reset();
    chk("rst.target", target_a, 429482970);
    chk("rst.busy",   busy_a,   0);
    chk("rst.done",   done_a,   0);
    chk("rst.ovf",    ovf_a,    0);

    // Jump: value 10, slew 0
    drive(1, 10, 0);                       // E0
    chk("jump.busy_e0", busy_a, 1);
    chk("jump.hold_e0", target_a, 429482970);
    drive(0, 0, 0);                        // E1
    chk("jump.done_e1", done_a, 0);
    drive(0, 0, 0);                        // E2
    chk("jump.target_e2", target_a, 429487270);
    chk("jump.done_e2", done_a, 1);
    drive(0, 0, 0);
    chk("jump.done_after", done_a, 0);
    chk("jump.busy_after", busy_a, 0);

    // Slew ramp: value 63, slew 1000, tick every cycle
    do_reset();
    slew = 16'd1000;
    drive(1, 63, 1);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      drive(0, 0, 1);
      n++;
      if (done_a) seen = 1'b1;
    end
    chk("ramp.seen_done", seen, 1);
    chk("ramp.cycles", n, SLEW_EN ? 29 : 2);
    chk("ramp.target", target_a, 429510060);
    drive(0, 0, 1);
    chk("ramp.idle_hold", target_a, 429510060);

    // Reversal: load 0 with tick during the ramp
    do_reset();
    drive(1, 63, 0);
    drive(0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 1);
`ifdef TARGET_RAMP_SLEW_EN
    chk("rev.mid", target_a, 429487970);
`endif
    drive(1, 0, 1);
    chk("rev.no_jump", target_a, SLEW_EN ? 429487970 : 429510060);
    n = 0; dones = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      drive(0, 0, 1);
      n++;
      if (done_a) begin seen = 1'b1; dones++; end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1);
      if (done_a) dones++;
    end
    chk("rev.cycles", n, SLEW_EN ? 6 : 2);
    chk("rev.target", target_a, 429482970);
    chk("rev.dones", dones, 1);

    // Saturation on the high-BASE instance
    do_reset();
    slew = 16'd0;
    drive(1, 1, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("sat.target", target_b, 64'hFFFF_FFFF);
    chk("sat.ovf_b", ovf_b, 1);
    chk("sat.ovf_a", ovf_a, 0);
    drive(0, 0, 0);
    chk("sat.ovf_sticky", ovf_b, 1);
    drive(1, 0, 0);
    chk("sat.ovf_clear", ovf_b, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("sat.back_base", target_b, 64'hFFFF_FF00);
    chk("sat.done", done_b, 1);

    // Reset in the middle of a ramp
    do_reset();
    slew = 16'd1000;
    drive(1, 63, 0);
    drive(0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 1);
    reset = 1'b1;
    drive(0, 0, 1);
    reset = 1'b0;
    chk("mid.target", target_a, 429482970);
    chk("mid.busy", busy_a, 0);
    chk("mid.done", done_a, 0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1);
      if (done_a) dones++;
    end
    chk("mid.no_done", dones, 0);

`ifndef TARGET_RAMP_SLEW_EN
    // Ramp option off: slew is ignored and RAMP jumps
    do_reset();
    slew = 16'd1000;
    drive(1, 63, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("nomacro.target_e2", target_a, 429510060);
    chk("nomacro.done_e2", done_a, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
